// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's request/grant/read-return bundle.
interface mem_port_arbiter_if;
   logic        req;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: bounded-burst two-requester arbiter for BRAM port B with 1-cycle read return and range check.
module mem_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DEPTH = 1024,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave m0,
   mem_port_arbiter_if.slave m1,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);
   localparam logic [3:0] MAXC = 4'(MAX_BURST);
   logic        owner;
   logic [3:0]  burst_cnt;
   logic        any;
   logic        sel;
   logic        oor;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        rd_v;
   logic        err_v;
   logic        tag_id;
   logic        tag_err;
   always_comb begin
      any = !reset && (m0.req || m1.req);
      sel = (m0.req && m1.req) ? ((burst_cnt == MAXC) ? !owner : owner) : m1.req;
      we = sel ? m1.we : m0.we;
      addr = sel ? m1.addr : m0.addr;
      wdata = sel ? m1.wdata : m0.wdata;
      // word address >= DEPTH, compared on the byte address so the low bits need no slicing
      oor = {2'b00, addr} >= (34'(DEPTH) << 2);
      m0.gnt = any && !sel;
      m1.gnt = any && sel;
      mem_en = any && !oor;
      mem_we = mem_en ? we : 4'b0000;
      mem_addr = any ? addr[ADDR_W+1:2] : '0;
      mem_din = any ? wdata : '0;
      m0.rvalid = !reset && rd_v && !tag_id;
      m1.rvalid = !reset && rd_v && tag_id;
      m0.rdata = (m0.rvalid && !tag_err) ? mem_dout : '0;
      m1.rdata = (m1.rvalid && !tag_err) ? mem_dout : '0;
      m0.err = !reset && err_v && !tag_id;
      m1.err = !reset && err_v && tag_id;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= 1'b0;
         burst_cnt <= 4'd0;
         rd_v <= 1'b0;
         err_v <= 1'b0;
         tag_id <= 1'b0;
         tag_err <= 1'b0;
      end else begin
         rd_v <= any && we == 4'b0000;
         err_v <= any && oor;
         tag_id <= sel;
         tag_err <= oor;
         if (any) begin
            if (sel == owner) begin
               burst_cnt <= (burst_cnt == MAXC) ? burst_cnt : burst_cnt + 4'd1;
            end else begin
               owner <= sel;
               burst_cnt <= 4'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table vectors, directed corner sequences and random traffic against a behavioural model.
module tb_mem_port_arbiter;
   localparam int MB = 4;
   localparam int DEPTH = 1024;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout = '0;
   mem_port_arbiter_if m0();
   mem_port_arbiter_if m1();
   mem_port_arbiter #(.ADDR_W(10), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset), .m0(m0), .m1(m1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] init_word(int i);
      logic [15:0] h;
      h = 16'(i);
      return i == 4 ? 32'hDEADBEEF : i == 8 ? 32'h12345678 : {h ^ 16'hA5C3, ~h};
   endfunction
   function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction
   // write-first BRAM port B with one-cycle read latency
   logic [31:0] bram [DEPTH];
   bit loaded;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
         loaded <= 1'b1;
      end else if (mem_en) begin
         bram[mem_addr] <= merge(bram[mem_addr], mem_din, mem_we);
         mem_dout <= merge(bram[mem_addr], mem_din, mem_we);
      end
   end
   int n_cmp = 0;
   int n_bad = 0;
   int m_owner = 0;
   int m_cnt = 0;
   int last_w = -1;
   bit e_rv [2];
   bit e_err [2];
   logic [31:0] e_rd [2];
   logic [31:0] sh [DEPTH];
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic step();
      int w;
      logic [3:0] we;
      logic [31:0] a;
      logic [31:0] d;
      bit oor;
      int idx;
      chk("m0_rvalid", 32'(m0.rvalid), reset ? 0 : 32'(e_rv[0]));
      chk("m1_rvalid", 32'(m1.rvalid), reset ? 0 : 32'(e_rv[1]));
      chk("m0_rdata", m0.rdata, reset ? 0 : e_rd[0]);
      chk("m1_rdata", m1.rdata, reset ? 0 : e_rd[1]);
      chk("m0_err", 32'(m0.err), reset ? 0 : 32'(e_err[0]));
      chk("m1_err", 32'(m1.err), reset ? 0 : 32'(e_err[1]));
      w = -1;
      if (!reset) begin
         if (m0.req && m1.req) w = (m_cnt == MB) ? 1 - m_owner : m_owner;
         else if (m0.req) w = 0;
         else if (m1.req) w = 1;
      end
      chk("m0_gnt", 32'(m0.gnt), 32'(w == 0));
      chk("m1_gnt", 32'(m1.gnt), 32'(w == 1));
      for (int i = 0; i < 2; i++) begin
         e_rv[i] = 0;
         e_err[i] = 0;
         e_rd[i] = '0;
      end
      if (w >= 0) begin
         we = (w == 1) ? m1.we : m0.we;
         a = (w == 1) ? m1.addr : m0.addr;
         d = (w == 1) ? m1.wdata : m0.wdata;
         oor = a[31:2] >= 30'(DEPTH);
         idx = int'(a[11:2]);
         chk("mem_en", 32'(mem_en), 32'(!oor));
         chk("mem_we", 32'(mem_we), oor ? 0 : 32'(we));
         if (!oor) begin
            chk("mem_addr", 32'(mem_addr), 32'(idx));
            chk("mem_din", mem_din, d);
            if (we != 0) sh[idx] = merge(sh[idx], d, we);
         end
         e_err[w] = oor;
         e_rv[w] = (we == 0);
         e_rd[w] = (we == 0 && !oor) ? sh[idx] : '0;
         if (w == m_owner) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
         else begin
            m_owner = w;
            m_cnt = 1;
         end
      end else begin
         chk("idle_mem_en", 32'(mem_en), 0);
         chk("idle_mem_we", 32'(mem_we), 0);
         chk("idle_mem_addr", 32'(mem_addr), 0);
         chk("idle_mem_din", mem_din, 0);
      end
      if (reset) begin
         m_owner = 0;
         m_cnt = 0;
      end
      last_w = w;
   endtask
   task automatic drive(int i, bit r, logic [3:0] we, logic [31:0] a, logic [31:0] d);
      if (i == 0) begin
         m0.req = r; m0.we = we; m0.addr = a; m0.wdata = d;
      end else begin
         m1.req = r; m1.we = we; m1.addr = a; m1.wdata = d;
      end
   endtask
   task automatic neg();
      @(negedge clk);
      step();
   endtask
   task automatic adv();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] rand_addr();
      logic [29:0] w;
      int k;
      k = $urandom_range(0, 9);
      w = k < 7 ? 30'($urandom_range(0, 15)) : k == 7 ? 30'($urandom_range(1020, 1023)) :
          k == 8 ? 30'($urandom_range(1024, 1030)) : 30'($urandom);
      return {w, 2'($urandom)};
   endfunction
   typedef struct {
      bit rst; bit r0; bit r1; logic [31:0] a0; logic [31:0] a1; bit g0; bit g1; bit en;
   } vec_t;
   vec_t tv[$];
   task automatic add(bit rst, bit r0, bit r1, logic [31:0] a0, logic [31:0] a1, bit g0, bit g1, bit en);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.g0 = g0; v.g1 = g1; v.en = en;
      tv.push_back(v);
   endtask
   initial begin
      for (int i = 0; i < DEPTH; i++) sh[i] = init_word(i);
      drive(0, 0, 4'h0, 0, 0);
      drive(1, 0, 4'h0, 0, 0);
      add(1, 1, 1, 32'h10, 32'h24, 0, 0, 0);
      add(1, 1, 1, 32'h10, 32'h24, 0, 0, 0);
      for (int i = 0; i < 9; i++) add(0, 1, 1, 32'h10, 32'h24, (i % 8) < 4, (i % 8) >= 4, 1);
      add(1, 1, 1, 32'h10, 32'h24, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 1, 32'h10, 32'h24, 0, 1, 1);
      add(0, 1, 1, 32'h10, 32'h24, 1, 0, 1);
      add(0, 1, 1, 32'h14, 32'h24, 1, 0, 1);
      add(0, 0, 0, 32'h10, 32'h24, 0, 0, 0);
      add(0, 1, 0, 32'h1000, 32'h24, 1, 0, 0);
      add(0, 0, 0, 32'h10, 32'h24, 0, 0, 0);
      add(0, 1, 0, 32'hFFC, 32'h24, 1, 0, 1);
      add(0, 1, 0, 32'hFFFFFFFC, 32'h24, 1, 0, 0);
      add(0, 0, 1, 32'h10, 32'h1003, 0, 1, 0);
      add(0, 0, 0, 32'h10, 32'h24, 0, 0, 0);
      adv();
      foreach (tv[k]) begin
         reset = tv[k].rst;
         drive(0, tv[k].r0, 4'h0, tv[k].a0, 0);
         drive(1, tv[k].r1, 4'h0, tv[k].a1, 0);
         neg();
         chk("tv_g0", 32'(m0.gnt), 32'(tv[k].g0));
         chk("tv_g1", 32'(m1.gnt), 32'(tv[k].g1));
         chk("tv_en", 32'(mem_en), 32'(tv[k].en));
         adv();
      end
      // single in-range read
      drive(0, 1, 4'h0, 32'h10, 0);
      neg();
      chk("rd_gnt", 32'(m0.gnt), 1);
      chk("rd_addr", 32'(mem_addr), 4);
      adv();
      drive(0, 0, 4'h0, 0, 0);
      neg();
      chk("rd_rvalid", 32'(m0.rvalid), 1);
      chk("rd_rdata", m0.rdata, 32'hDEADBEEF);
      chk("rd_m1_rvalid", 32'(m1.rvalid), 0);
      adv();
      // byte write by m1, then read-after-write by m0
      drive(1, 1, 4'b0010, 32'h20, 32'h0000AB00);
      neg();
      chk("wr_gnt", 32'(m1.gnt), 1);
      chk("wr_we", 32'(mem_we), 32'b0010);
      adv();
      drive(1, 0, 4'h0, 0, 0);
      drive(0, 1, 4'h0, 32'h20, 0);
      neg();
      chk("raw_gnt", 32'(m0.gnt), 1);
      chk("wr_no_rvalid", 32'(m1.rvalid), 0);
      adv();
      drive(0, 0, 4'h0, 0, 0);
      neg();
      chk("raw_rdata", m0.rdata, 32'h1234AB78);
      adv();
      // read granted, then reset: no rvalid, then first conflict to m0
      drive(0, 1, 4'h0, 32'h10, 0);
      neg();
      chk("pre_rst_gnt", 32'(m0.gnt), 1);
      adv();
      reset = 1;
      drive(0, 1, 4'h0, 32'h10, 0);
      drive(1, 1, 4'h0, 32'h24, 0);
      neg();
      chk("rst_rvalid", 32'(m0.rvalid), 0);
      chk("rst_gnt1", 32'(m1.gnt), 0);
      chk("rst_en", 32'(mem_en), 0);
      adv();
      reset = 0;
      neg();
      chk("post_rst_rvalid", 32'(m0.rvalid), 0);
      chk("post_rst_gnt0", 32'(m0.gnt), 1);
      adv();
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 149) == 0);
         for (int i = 0; i < 2; i++) begin
            bit r;
            r = (i == 1) ? m1.req : m0.req;
            if (r && (last_w == i || $urandom_range(0, 15) == 0)) begin
               r = 0;
               if (i == 1) m1.req = 0; else m0.req = 0;
            end
            if (!r && $urandom_range(0, 2) != 0)
               drive(i, 1, $urandom_range(0, 1) ? 4'h0 : 4'($urandom), rand_addr(), $urandom);
         end
         neg();
         adv();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the data port (port B) of the shared instruction/data BRAM. It multiplexes the CPU load/store path (requester 0) and the UART program loader (requester 1) onto the single BRAM port. It enforces a bounded-burst fairness policy, tracks the one-cycle synchronous read latency, and flags out-of-range accesses. Port A (instruction fetch) is untouched. The block sits between the request sources and the memory-mapped I/O decode, in front of the `mem` instance.

## Interface
- `ADDR_W`, 10, BRAM word-address width (1024 words).
- `DEPTH`, 1024, number of implemented words; word addresses >= DEPTH are out of range.
- `MAX_BURST`, 4, maximum consecutive grants to one requester while the other is waiting; legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mN_req` in 1 (N=0,1): request; held stable with its qualifiers until `mN_gnt`.
- `mN_we` in 4: byte write mask, already lane-aligned; 4'b0000 means read.
- `mN_addr` in 32: byte address; bits [1:0] ignored; word address = addr[31:2].
- `mN_wdata` in 32: lane-aligned write data.
- `mN_gnt` out 1: request accepted this cycle (combinational).
- `mN_rvalid` out 1: read data valid, one cycle after a read grant.
- `mN_rdata` out 32: read word; 0 when `mN_rvalid` is low.
- `mN_err` out 1: pulse one cycle after the grant of an out-of-range access.
- `mem_en` out 1: BRAM port B enable.
- `mem_we` out 4: BRAM port B byte write enables.
- `mem_addr` out ADDR_W: BRAM port B word address.
- `mem_din` out 32: BRAM port B write data.
- `mem_dout` in 32: BRAM port B read data, valid one cycle after `mem_en`.

## Operation
- State registers:
  - `owner` (0/1): last granted requester.
  - `burst_cnt` (4 bits, saturating at MAX_BURST): consecutive grants to `owner`.
  - Pending-read tag: valid, requester id, err.
- Arbitration, evaluated each cycle when `reset`=0:
  - Only one `req` high: grant it.
  - Both high, and `burst_cnt` < MAX_BURST: grant `owner`.
  - Both high, and `burst_cnt` = MAX_BURST: grant the other requester.
  - Neither high: no grant; `owner` and `burst_cnt` hold.
- On a grant to X:
  - If X == `owner`: `burst_cnt` <= min(`burst_cnt`+1, MAX_BURST).
  - Otherwise: `owner` <= X and `burst_cnt` <= 1.
- At most one `gnt` per cycle. One access is accepted per cycle, back-to-back, with no bubbles.
- In-range grant: `mem_en`=1, `mem_we`=X_we, `mem_addr`=X_addr[ADDR_W+1:2], `mem_din`=X_wdata, all in the grant cycle.
- Out-of-range grant (addr[31:2] >= DEPTH):
  - `mem_en`=0 and `mem_we`=0.
  - The access is still granted and completes: `err` pulses next cycle.
  - A read also pulses `rvalid` with `rdata`=0.
  - A write is dropped.
- No grant: `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
- Read completion: in the cycle after a read grant, the granted requester sees `rvalid`=1 and `rdata`=`mem_dout` (in range) or 0 (out of range). The other requester's `rvalid` and `rdata` stay 0.
- Writes produce no `rvalid`.

## Timing
- Grant cycle: `gnt` and `mem_*` are combinational from `req`, `owner` and `burst_cnt`. The BRAM samples at the end of the grant cycle.
- Read latency: exactly 1 cycle from grant to `rvalid`. Write completes at the grant-cycle edge.
- Read-after-write to the same word by consecutive grants returns the new data (BRAM write-first on port B).
- Reset, synchronous:
  - Registers on the clock edge with `reset`=1: `owner`=0, `burst_cnt`=0, pending tag cleared.
  - While `reset`=1: both `gnt`=0 and `mem_en`=0.
  - Registered outputs are 0 in the cycle after reset is sampled.
  - A read granted in the cycle before reset asserts never produces `rvalid`.
- First conflict after reset grants requester 0 (owner=0, cnt=0 < MAX_BURST).
- MAX_BURST=1 gives strict alternation under continuous contention.
- Requester that drops `req` without a grant: no side effect. Fairness counters are updated only on grants.

## Test plan
- Single read, m0 addr=0x10, BRAM word 4 = 0xDEADBEEF -> `m0_gnt` same cycle, `mem_addr`=4, `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF next cycle; `m1_rvalid`=0.
- Continuous contention, both reads, MAX_BURST=4, from reset -> grant sequence 0,0,0,0,1,1,1,1,0,... with no idle cycles.
- m1 writes we=4'b0010, wdata=0x0000AB00 to addr 0x20, then m0 reads 0x20 the next cycle -> `mem_we`=4'b0010 on the write; read returns byte 1 = 0xAB, other bytes unchanged.
- m0 read at addr 0x1000 (word 1024, DEPTH=1024) -> `gnt`=1, `mem_en`=0, next cycle `m0_err`=1, `m0_rvalid`=1, `m0_rdata`=0.
- Read granted, `reset` asserted the next cycle -> no `rvalid`; all outputs 0 after the edge; first post-reset conflict goes to m0.
- Only m1 requests for 10 cycles, then m0 joins -> m1 granted every cycle; m0 granted on the first conflict cycle (cnt saturated at 4).
